// File: rtl/vctrl_pkg.sv
// Shared definitions for the video timing register file: register map, bit positions
// within ctrl/cmd/status, commit FSM states and the default ID value.
package vctrl_pkg;

   localparam int NUM_FIELDS = 8;

   localparam int FLD_H_ACTIVE     = 0;
   localparam int FLD_H_SYNC_START = 1;
   localparam int FLD_H_SYNC_END   = 2;
   localparam int FLD_H_TOTAL      = 3;
   localparam int FLD_V_ACTIVE     = 4;
   localparam int FLD_V_SYNC_START = 5;
   localparam int FLD_V_SYNC_END   = 6;
   localparam int FLD_V_TOTAL      = 7;

   localparam logic [4:0] REG_CTRL   = 5'h10;
   localparam logic [4:0] REG_CMD    = 5'h11;
   localparam logic [4:0] REG_STATUS = 5'h12;
   localparam logic [4:0] REG_FRAME  = 5'h13;
   localparam logic [4:0] REG_ID     = 5'h1F;

   localparam int CTRL_VIDEO = 0;
   localparam int CTRL_HDMI  = 1;
   localparam int CTRL_VGA   = 2;
   localparam int CTRL_V_POL = 3;
   localparam int CTRL_H_POL = 4;

   localparam int CMD_COMMIT = 0;
   localparam int CMD_CANCEL = 1;

   localparam int STAT_PEND  = 0;
   localparam int STAT_ERR   = 1;
   localparam int STAT_VIDEO = 2;

   localparam logic [7:0] ID_DEFAULT = 8'h1B;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } commit_state_e;

endpackage

// File: rtl/vtiming_check.sv
// One-axis timing ordering check: 0 < active < sync_start < sync_end < total (unsigned).
module vtiming_check
   import vctrl_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  logic [CNT_W-1:0] i_active,
   input  logic [CNT_W-1:0] i_sync_start,
   input  logic [CNT_W-1:0] i_sync_end,
   input  logic [CNT_W-1:0] i_total,
   output logic             o_ok
);

   assign o_ok = (i_active != '0)
               && (i_active     < i_sync_start)
               && (i_sync_start < i_sync_end)
               && (i_sync_end   < i_total);

endmodule

// File: rtl/vctrl_regs_shadow.sv
// Double-buffered CPU register file for the video timing generator. The CPU edits a shadow
// copy; a validated commit moves it to the active copy atomically at a frame boundary.
module vctrl_regs_shadow
   import vctrl_pkg::*;
#(
   parameter int         CNT_W  = 12,
   parameter int         ADDR_W = 6,
   parameter logic [7:0] ID_VAL = ID_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_data_wr,
   input  logic              i_select,
   input  logic              i_wr_req,
   output logic [7:0]        o_data_rd,
   input  logic              i_frame_start,
   output logic [CNT_W-1:0]  o_h_active,
   output logic [CNT_W-1:0]  o_h_sync_start,
   output logic [CNT_W-1:0]  o_h_sync_end,
   output logic [CNT_W-1:0]  o_h_total,
   output logic [CNT_W-1:0]  o_v_active,
   output logic [CNT_W-1:0]  o_v_sync_start,
   output logic [CNT_W-1:0]  o_v_sync_end,
   output logic [CNT_W-1:0]  o_v_total,
   output logic              o_h_sync_pol,
   output logic              o_v_sync_pol,
   output logic              o_video_en,
   output logic              o_hdmi_en,
   output logic              o_vga_en,
   output logic              o_commit_done,
   output logic              o_cfg_err
);

   logic [4:0] reg_idx;
   logic       rd_active;
   logic       wr_en;
   logic       wr_field;
   logic       wr_ctrl;
   logic       wr_cmd;
   logic       wr_status;

   assign reg_idx   = i_addr[4:0];
   assign rd_active = i_addr[5];
   assign wr_en     = i_select & i_wr_req;
   assign wr_field  = wr_en & ~reg_idx[4];
   assign wr_ctrl   = wr_en & (reg_idx == REG_CTRL);
   assign wr_cmd    = wr_en & (reg_idx == REG_CMD);
   assign wr_status = wr_en & (reg_idx == REG_STATUS);

   logic [CNT_W-1:0] shadow_q [NUM_FIELDS];
   logic [CNT_W-1:0] shadow_d [NUM_FIELDS];
   logic [CNT_W-1:0] active_q [NUM_FIELDS];
   logic             h_pol_sh_q, h_pol_sh_d;
   logic             v_pol_sh_q, v_pol_sh_d;
   logic             h_pol_act_q;
   logic             v_pol_act_q;
   logic             video_en_q, video_en_d;
   logic             hdmi_en_q, hdmi_en_d;
   logic             vga_en_q, vga_en_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   commit_state_e    state_q;
   logic             commit_done_q;
   logic             cfg_err_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      shadow_d    = shadow_q;
      h_pol_sh_d  = h_pol_sh_q;
      v_pol_sh_d  = v_pol_sh_q;
      video_en_d  = video_en_q;
      hdmi_en_d   = hdmi_en_q;
      vga_en_d    = vga_en_q;
      frame_cnt_d = frame_cnt_q + {7'b0, i_frame_start};

      // Byte 1 keeps only the bits that fit in CNT_W; the rest of the write is dropped.
      if (wr_field) begin
         if (reg_idx[0] == 1'b0) begin
            shadow_d[reg_idx[3:1]] = {shadow_q[reg_idx[3:1]][CNT_W-1:8], i_data_wr};
         end else begin
            shadow_d[reg_idx[3:1]] = {i_data_wr[CNT_W-9:0], shadow_q[reg_idx[3:1]][7:0]};
         end
      end

      if (wr_ctrl) begin
         video_en_d = i_data_wr[CTRL_VIDEO];
         hdmi_en_d  = i_data_wr[CTRL_HDMI];
         vga_en_d   = i_data_wr[CTRL_VGA];
         v_pol_sh_d = i_data_wr[CTRL_V_POL];
         h_pol_sh_d = i_data_wr[CTRL_H_POL];
      end
   end

   // NOTE: the shadow array is small and software expects it to read 0 after reset, so it
   // is reset like any other register rather than left as uninitialised storage.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_FIELDS; i++) begin
            shadow_q[i] <= '0;
         end
         h_pol_sh_q  <= 1'b0;
         v_pol_sh_q  <= 1'b0;
         video_en_q  <= 1'b0;
         hdmi_en_q   <= 1'b0;
         vga_en_q    <= 1'b0;
         frame_cnt_q <= 8'h00;
      end else begin
         shadow_q    <= shadow_d;
         h_pol_sh_q  <= h_pol_sh_d;
         v_pol_sh_q  <= v_pol_sh_d;
         video_en_q  <= video_en_d;
         hdmi_en_q   <= hdmi_en_d;
         vga_en_q    <= vga_en_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   logic h_ok;
   logic v_ok;

   vtiming_check #(.CNT_W(CNT_W)) u_h_check (
      .i_active     (shadow_q[FLD_H_ACTIVE]),
      .i_sync_start (shadow_q[FLD_H_SYNC_START]),
      .i_sync_end   (shadow_q[FLD_H_SYNC_END]),
      .i_total      (shadow_q[FLD_H_TOTAL]),
      .o_ok         (h_ok)
   );

   vtiming_check #(.CNT_W(CNT_W)) u_v_check (
      .i_active     (shadow_q[FLD_V_ACTIVE]),
      .i_sync_start (shadow_q[FLD_V_SYNC_START]),
      .i_sync_end   (shadow_q[FLD_V_SYNC_END]),
      .i_total      (shadow_q[FLD_V_TOTAL]),
      .o_ok         (v_ok)
   );

   // Commit FSM. Resolution samples the registered shadow, so a same-cycle CPU write lands
   // in the shadow only and never leaks into the active copy.
   // NOTE: non-blocking assignments here, and the later assignment of cfg_err_q wins, which
   // is how a rejection overrides a W1C clear issued in the same cycle.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q       <= ST_IDLE;
         commit_done_q <= 1'b0;
         cfg_err_q     <= 1'b0;
         h_pol_act_q   <= 1'b0;
         v_pol_act_q   <= 1'b0;
         for (int i = 0; i < NUM_FIELDS; i++) begin
            active_q[i] <= '0;
         end
      end else begin
         commit_done_q <= 1'b0;
         if (wr_status && i_data_wr[STAT_ERR]) begin
            cfg_err_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (wr_cmd && i_data_wr[CMD_COMMIT] && !i_data_wr[CMD_CANCEL]) begin
                  state_q <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (wr_cmd && i_data_wr[CMD_CANCEL]) begin
                  state_q <= ST_IDLE;
               end else if (i_frame_start || !video_en_q) begin
                  state_q       <= ST_IDLE;
                  commit_done_q <= 1'b1;
                  if (h_ok && v_ok) begin
                     active_q    <= shadow_q;
                     h_pol_act_q <= h_pol_sh_q;
                     v_pol_act_q <= v_pol_sh_q;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic [CNT_W-1:0] rd_field;
   logic             rd_h_pol;
   logic             rd_v_pol;
   logic [7:0]       rd_data;

   always_comb begin
      rd_field = rd_active ? active_q[reg_idx[3:1]] : shadow_q[reg_idx[3:1]];
      rd_h_pol = rd_active ? h_pol_act_q : h_pol_sh_q;
      rd_v_pol = rd_active ? v_pol_act_q : v_pol_sh_q;
      rd_data  = 8'h00;
      if (!reg_idx[4]) begin
         rd_data = reg_idx[0] ? 8'(rd_field[CNT_W-1:8]) : rd_field[7:0];
      end else begin
         case (reg_idx)
            REG_CTRL: begin
               rd_data[CTRL_VIDEO] = video_en_q;
               rd_data[CTRL_HDMI]  = hdmi_en_q;
               rd_data[CTRL_VGA]   = vga_en_q;
               rd_data[CTRL_V_POL] = rd_v_pol;
               rd_data[CTRL_H_POL] = rd_h_pol;
            end
            REG_STATUS: begin
               rd_data[STAT_PEND]  = (state_q == ST_PEND);
               rd_data[STAT_ERR]   = cfg_err_q;
               rd_data[STAT_VIDEO] = video_en_q;
            end
            REG_FRAME: rd_data = frame_cnt_q;
            REG_ID:    rd_data = ID_VAL;
            default:   rd_data = 8'h00;
         endcase
      end
   end

   assign o_data_rd      = rd_data;
   assign o_h_active     = active_q[FLD_H_ACTIVE];
   assign o_h_sync_start = active_q[FLD_H_SYNC_START];
   assign o_h_sync_end   = active_q[FLD_H_SYNC_END];
   assign o_h_total      = active_q[FLD_H_TOTAL];
   assign o_v_active     = active_q[FLD_V_ACTIVE];
   assign o_v_sync_start = active_q[FLD_V_SYNC_START];
   assign o_v_sync_end   = active_q[FLD_V_SYNC_END];
   assign o_v_total      = active_q[FLD_V_TOTAL];
   assign o_h_sync_pol   = h_pol_act_q;
   assign o_v_sync_pol   = v_pol_act_q;
   assign o_video_en     = video_en_q;
   assign o_hdmi_en      = hdmi_en_q;
   assign o_vga_en       = vga_en_q;
   assign o_commit_done  = commit_done_q;
   assign o_cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_vctrl_regs_shadow.sv
// Self-checking bench: directed scenarios plus random traffic, compared against a
// register-level behavioural model built from the documented register rules.
module tb_vctrl_regs_shadow;

   localparam int CNT_W = 12;
   localparam int MASK  = (1 << CNT_W) - 1;

   logic             i_clk = 1'b0;
   logic             i_reset_n = 1'b0;
   logic [5:0]       i_addr = '0;
   logic [7:0]       i_data_wr = '0;
   logic             i_select = 1'b0;
   logic             i_wr_req = 1'b0;
   logic             i_frame_start = 1'b0;
   logic [7:0]       o_data_rd;
   logic [CNT_W-1:0] o_h_active, o_h_sync_start, o_h_sync_end, o_h_total;
   logic [CNT_W-1:0] o_v_active, o_v_sync_start, o_v_sync_end, o_v_total;
   logic             o_h_sync_pol, o_v_sync_pol, o_video_en, o_hdmi_en, o_vga_en;
   logic             o_commit_done, o_cfg_err;

   vctrl_regs_shadow #(.CNT_W(CNT_W), .ADDR_W(6), .ID_VAL(8'h1B)) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_addr         (i_addr),
      .i_data_wr      (i_data_wr),
      .i_select       (i_select),
      .i_wr_req       (i_wr_req),
      .o_data_rd      (o_data_rd),
      .i_frame_start  (i_frame_start),
      .o_h_active     (o_h_active),
      .o_h_sync_start (o_h_sync_start),
      .o_h_sync_end   (o_h_sync_end),
      .o_h_total      (o_h_total),
      .o_v_active     (o_v_active),
      .o_v_sync_start (o_v_sync_start),
      .o_v_sync_end   (o_v_sync_end),
      .o_v_total      (o_v_total),
      .o_h_sync_pol   (o_h_sync_pol),
      .o_v_sync_pol   (o_v_sync_pol),
      .o_video_en     (o_video_en),
      .o_hdmi_en      (o_hdmi_en),
      .o_vga_en       (o_vga_en),
      .o_commit_done  (o_commit_done),
      .o_cfg_err      (o_cfg_err)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;

   // Reference model state: plain integers per register, not per flop.
   int m_sh [8];
   int m_ac [8];
   bit m_sh_hpol, m_sh_vpol, m_ac_hpol, m_ac_vpol;
   bit m_video, m_hdmi, m_vga, m_pend, m_err, m_done;
   int m_frame;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit axis_ok(input int a, input int ss, input int se, input int t);
      return (a > 0) && (a < ss) && (ss < se) && (se < t);
   endfunction

   function automatic logic [7:0] model_read(input logic [5:0] a);
      int idx;
      int v;
      bit act;
      idx = int'(a[4:0]);
      act = a[5];
      if (idx < 16) begin
         v = act ? m_ac[idx / 2] : m_sh[idx / 2];
         return 8'((v >> (8 * (idx % 2))) & 255);
      end
      case (idx)
         16: return {3'b000, act ? m_ac_hpol : m_sh_hpol, act ? m_ac_vpol : m_sh_vpol,
                     m_vga, m_hdmi, m_video};
         18: return {5'b00000, m_video, m_err, m_pend};
         19: return 8'(m_frame);
         31: return 8'h1B;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_step(input logic rst, input logic sel, input logic wr,
                             input logic [5:0] addr, input logic [7:0] data, input logic fs);
      int pre_sh [8];
      bit pre_hpol, pre_vpol, pre_video, pre_pend, we, cmd;
      int idx, f, sh, d;
      if (!rst) begin
         for (int i = 0; i < 8; i++) begin
            m_sh[i] = 0;
            m_ac[i] = 0;
         end
         {m_sh_hpol, m_sh_vpol, m_ac_hpol, m_ac_vpol} = '0;
         {m_video, m_hdmi, m_vga, m_pend, m_err, m_done} = '0;
         m_frame = 0;
         return;
      end
      pre_sh    = m_sh;
      pre_hpol  = m_sh_hpol;
      pre_vpol  = m_sh_vpol;
      pre_video = m_video;
      pre_pend  = m_pend;
      we        = sel && wr;
      idx       = int'(addr[4:0]);
      d         = int'(data);
      m_done    = 0;
      if (we && idx < 16) begin
         f  = idx / 2;
         sh = 8 * (idx % 2);
         m_sh[f] = ((m_sh[f] & ~(255 << sh)) | (d << sh)) & MASK;
      end else if (we && idx == 16) begin
         {m_sh_hpol, m_sh_vpol, m_vga, m_hdmi, m_video} = data[4:0];
      end else if (we && idx == 18 && data[1]) begin
         m_err = 0;
      end
      cmd = we && idx == 17;
      if (cmd && data[1]) begin
         m_pend = 0;
      end else if (pre_pend) begin
         if (fs || !pre_video) begin
            m_pend = 0;
            m_done = 1;
            if (axis_ok(pre_sh[0], pre_sh[1], pre_sh[2], pre_sh[3]) &&
                axis_ok(pre_sh[4], pre_sh[5], pre_sh[6], pre_sh[7])) begin
               m_ac      = pre_sh;
               m_ac_hpol = pre_hpol;
               m_ac_vpol = pre_vpol;
            end else begin
               m_err = 1;
            end
         end
      end else if (cmd && data[0]) begin
         m_pend = 1;
      end
      m_frame = (m_frame + (fs ? 1 : 0)) % 256;
   endtask

   task automatic check_outputs();
      check("done", o_commit_done, m_done);
      check("cfg_err", o_cfg_err, m_err);
      check("h_active", o_h_active, m_ac[0]);
      check("h_sync_start", o_h_sync_start, m_ac[1]);
      check("h_sync_end", o_h_sync_end, m_ac[2]);
      check("h_total", o_h_total, m_ac[3]);
      check("v_active", o_v_active, m_ac[4]);
      check("v_sync_start", o_v_sync_start, m_ac[5]);
      check("v_sync_end", o_v_sync_end, m_ac[6]);
      check("v_total", o_v_total, m_ac[7]);
      check("h_pol", o_h_sync_pol, m_ac_hpol);
      check("v_pol", o_v_sync_pol, m_ac_vpol);
      check("enables", {o_vga_en, o_hdmi_en, o_video_en}, {m_vga, m_hdmi, m_video});
   endtask

   // One clock: inputs are driven a step after an edge, the model advances at the edge,
   // outputs are sampled 1 time unit later.
   task automatic cycle(input logic rst, input logic sel, input logic wr,
                        input logic [5:0] addr, input logic [7:0] data, input logic fs);
      i_reset_n     = rst;
      i_select      = sel;
      i_wr_req      = wr;
      i_addr        = addr;
      i_data_wr     = data;
      i_frame_start = fs;
      @(posedge i_clk);
      model_step(rst, sel, wr, addr, data, fs);
      #1;
      check_outputs();
      i_reset_n     = 1'b1;
      i_select      = 1'b0;
      i_wr_req      = 1'b0;
      i_frame_start = 1'b0;
   endtask

   task automatic wr(input logic [5:0] addr, input logic [7:0] data, input logic fs);
      cycle(1'b1, 1'b1, 1'b1, addr, data, fs);
   endtask

   task automatic idle(input logic fs);
      cycle(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, fs);
   endtask

   task automatic rd_check(input logic [5:0] addr);
      i_addr = addr;
      #1;
      check($sformatf("rd_%02h", addr), o_data_rd, model_read(addr));
   endtask

   task automatic write_field(input int f, input int val);
      wr(6'(2 * f), 8'(val & 255), 1'b0);
      wr(6'(2 * f + 1), 8'((val >> 8) & 255), 1'b0);
   endtask

   task automatic write_set(input int v[8]);
      for (int f = 0; f < 8; f++) write_field(f, v[f]);
   endtask

   initial begin
      int set_a [8];
      int set_r [8];
      int frame_before;

      set_a = '{1280, 1390, 1430, 1650, 720, 725, 730, 750};

      cycle(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0);
      for (int a = 0; a <= 8'h13; a++) begin
         rd_check(6'(a));
         rd_check(6'(a) | 6'h20);
      end
      i_addr = 6'h1F;
      #1;
      check("id", o_data_rd, 8'h1B);

      // Nominal 720p-like commit gated by frame start.
      write_set(set_a);
      wr(6'h10, 8'h01, 1'b0);
      wr(6'h11, 8'h01, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         rd_check(6'h12);
      end
      idle(1'b1);
      check("commit_pulse", o_commit_done, 1'b1);
      check("h_total_1650", o_h_total, 12'd1650);
      check("v_active_720", o_v_active, 12'd720);
      i_addr = 6'h26;
      #1;
      check("rd_active_26", o_data_rd, 8'h72);
      idle(1'b0);

      // Invalid h axis rejected, active untouched, then W1C clear.
      write_field(2, 1300);
      wr(6'h11, 8'h01, 1'b0);
      idle(1'b0);
      idle(1'b1);
      check("reject_err", o_cfg_err, 1'b1);
      rd_check(6'h12);
      wr(6'h12, 8'h02, 1'b0);
      rd_check(6'h12);
      write_field(2, 1430);

      // video_en=0: commit resolves on the following cycle without a frame start.
      wr(6'h10, 8'h18, 1'b0);
      write_field(0, 1024);
      wr(6'h11, 8'h01, 1'b0);
      idle(1'b0);
      check("no_video_apply", o_h_active, 12'd1024);
      rd_check(6'h20);
      rd_check(6'h30);

      // Commit then cancel; commit+cancel together.
      wr(6'h10, 8'h07, 1'b0);
      wr(6'h11, 8'h01, 1'b0);
      wr(6'h11, 8'h02, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      wr(6'h11, 8'h03, 1'b0);
      rd_check(6'h12);
      idle(1'b1);

      // Commit coinciding with frame start waits for the next one; repeat commit ignored.
      write_field(4, 700);
      wr(6'h11, 8'h01, 1'b1);
      rd_check(6'h12);
      wr(6'h11, 8'h01, 1'b0);
      idle(1'b0);
      idle(1'b1);
      check("late_apply", o_v_active, 12'd700);

      // Shadow write in the resolving cycle uses the pre-write shadow.
      wr(6'h11, 8'h01, 1'b0);
      wr(6'h08, 8'h10, 1'b1);
      rd_check(6'h28);
      rd_check(6'h08);

      // Rejection beats a same-cycle W1C.
      write_field(7, 100);
      wr(6'h11, 8'h01, 1'b0);
      wr(6'h12, 8'h02, 1'b1);
      check("err_wins", o_cfg_err, 1'b1);
      wr(6'h12, 8'h02, 1'b0);

      // Frame counter wraps after 256 frame starts.
      i_addr = 6'h13;
      #1;
      frame_before = int'(o_data_rd);
      for (int i = 0; i < 256; i++) idle(1'b1);
      i_addr = 6'h13;
      #1;
      check("frame_wrap", o_data_rd, 8'(frame_before));

      // Reset while pending: no done pulse, pending cleared.
      write_field(7, 750);
      wr(6'h11, 8'h01, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1);
      idle(1'b1);
      rd_check(6'h12);

      // Random traffic.
      for (int it = 0; it < 600; it++) begin
         int op;
         logic fs;
         op = int'($urandom_range(0, 19));
         fs = ($urandom_range(0, 5) == 0);
         if (op == 0) begin
            for (int ax = 0; ax < 2; ax++) begin
               set_r[4*ax]   = int'($urandom_range(1, 500));
               set_r[4*ax+1] = set_r[4*ax]   + int'($urandom_range(1, 100));
               set_r[4*ax+2] = set_r[4*ax+1] + int'($urandom_range(1, 100));
               set_r[4*ax+3] = set_r[4*ax+2] + int'($urandom_range(1, 200));
            end
            if ($urandom_range(0, 3) == 0) begin
               set_r[$urandom_range(0, 7)] = int'($urandom_range(0, MASK));
            end
            write_set(set_r);
         end else if (op <= 5) begin
            wr(6'($urandom_range(0, 15)), 8'($urandom), fs);
         end else if (op <= 8) begin
            wr(6'h10, 8'($urandom), fs);
         end else if (op <= 12) begin
            wr(6'h11, 8'($urandom_range(0, 3)), fs);
         end else if (op == 13) begin
            wr(6'h12, 8'($urandom), fs);
         end else if (op == 14) begin
            wr(6'($urandom_range(19, 31)), 8'($urandom), fs);
         end else if (op == 15 && $urandom_range(0, 9) == 0) begin
            cycle(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, fs);
         end else begin
            idle(fs);
         end
         rd_check(6'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
